program_loader: RTL

- Upstream feeder for the CPU control sequencer's programming path.
- After reset, on request, puts the sequencer into programming mode and synchronises entry and exit to instruction-cycle boundaries.
- Drives external pin data (ui_in) onto the internal bus each time the sequencer requests a word, counts completed RAM writes, and releases the CPU to run from address 0 once all words are loaded.

---
 rtl/program_loader.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
// Upstream feeder for the CPU control sequencer's programming path. On a
// prog_req strap it arms, enters programming mode on the next instruction
// cycle boundary (ready), drives ui_in onto the bus whenever the sequencer
// asks for a word, counts completed RAM writes and, once WORD_COUNT words
// are written, waits for the next boundary before releasing the CPU.
//
// Optional feature macro: PROG_LOADER_CHECKSUM_EN
//   defined   -> checksum is a running modulo-2^DATA_WIDTH sum of the loaded
//                words, held from DRAIN onward
//   undefined -> no accumulator exists, checksum is tied to zero
// ---------------------------------------------------------------------------
module program_loader #(
   parameter int WORD_COUNT = 16,
   parameter int DATA_WIDTH = 8,
   localparam int CW = $clog2(WORD_COUNT + 1)
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  prog_req,
   input  logic                  ready,
   input  logic                  read_ui_in,
   input  logic                  done_load,
   input  logic [DATA_WIDTH-1:0] ui_in,
   output logic                  programming,
   output logic                  bus_drive,
   output logic [DATA_WIDTH-1:0] bus_out,
   output logic [CW-1:0]         word_count,
   output logic                  prog_done,
   output logic [DATA_WIDTH-1:0] checksum
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARM   = 3'd1,
      ST_LOAD  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_RUN   = 3'd4
   } state_t;

   // Index of the final word; its RAM write completes the session.
   localparam logic [CW-1:0] LAST_IDX = CW'(WORD_COUNT - 1);

   state_t          state_r;
   logic            programming_r;
   logic            prog_done_r;
   logic [CW-1:0]   word_count_r;

   logic                  bus_drive_s;
   logic [DATA_WIDTH-1:0] bus_out_s;

   // Session FSM: mode entry/exit aligned to ready, word counting in LOAD.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_r       <= ST_IDLE;
         programming_r <= 1'b0;
         prog_done_r   <= 1'b0;
         word_count_r  <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (prog_req) begin
                  state_r <= ST_ARM;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_ARM: begin
               // ready wins over a dropped request: the boundary has arrived.
               if (ready) begin
                  state_r       <= ST_LOAD;
                  programming_r <= 1'b1;
               end else if (!prog_req) begin
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= ST_ARM;
               end
            end
            ST_LOAD: begin
               if (done_load) begin
                  word_count_r <= word_count_r + CW'(1);
                  if (word_count_r == LAST_IDX) begin
                     state_r <= ST_DRAIN;
                  end else begin
                     state_r <= ST_LOAD;
                  end
               end else begin
                  state_r <= ST_LOAD;
               end
            end
            ST_DRAIN: begin
               // Release on a boundary so the next fetch starts cleanly at
               // the wrapped PC (address 0).
               if (ready) begin
                  state_r       <= ST_RUN;
                  programming_r <= 1'b0;
                  prog_done_r   <= 1'b1;
               end else begin
                  state_r <= ST_DRAIN;
               end
            end
            ST_RUN: begin
               state_r <= ST_RUN;
            end
            default: begin
               state_r       <= ST_IDLE;
               programming_r <= 1'b0;
               prog_done_r   <= 1'b0;
               word_count_r  <= '0;
            end
         endcase
      end
   end

`ifdef PROG_LOADER_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] checksum_r;

   // Running sum of every word whose RAM write completes during LOAD.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         checksum_r <= '0;
      end else if (state_r == ST_LOAD && done_load) begin
         checksum_r <= checksum_r + ui_in;
      end else begin
         checksum_r <= checksum_r;
      end
   end

   assign checksum = checksum_r;
`else
   assign checksum = '0;
`endif

   // Bus gating: zero-latency pass-through of ui_in only while loading.
   always_comb begin
      bus_drive_s = 1'b0;
      bus_out_s   = '0;
      if (state_r == ST_LOAD && read_ui_in) begin
         bus_drive_s = 1'b1;
         bus_out_s   = ui_in;
      end else begin
         bus_drive_s = 1'b0;
         bus_out_s   = '0;
      end
   end

   assign programming = programming_r;
   assign prog_done   = prog_done_r;
   assign word_count  = word_count_r;
   assign bus_drive   = bus_drive_s;
   assign bus_out     = bus_out_s;

endmodule
